// File: rtl/sync_bad_top.sv
// sync_bad_top: three independently coded lanes of the collapsed
// "bad" two-stage synchronizer, which behaves as a single flop stage.
//
// Ports:
//   clk    rising-edge clock shared by every lane
//   reset  synchronous active-high reset shared by every lane
//   d      asynchronous-origin data input shared by every lane
//   q_sv   SystemVerilog-style lane output
//   q_v    Verilog-style lane output
//   q_vhd  VHDL-style lane output

// SystemVerilog-style lane.
// Ports: i_clk, i_reset (sync, high), i_d -> o_q.
module sync_bad_lane_sv (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic w_n1;
  logic r_n1;
  logic r_q;

  // Value n1 holds once the in-edge update chain has run.
  // q is then loaded from this new n1, not the old one.
  always_comb begin
    w_n1 = i_d;
    if (i_reset) w_n1 = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    r_n1 <= w_n1;
    r_q  <= w_n1;
  end

  assign o_q = r_q;

  // The stage never holds anything q does not already hold.
  a_collapse: assert property (
    @(posedge i_clk) 1'b1 |=> (r_n1 == r_q)
  );

endmodule

// Verilog-style lane.
// Ports: i_clk, i_reset (sync, high), i_d -> o_q.
module sync_bad_lane_v (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_n1;
  logic r_q;

  // Both registers load d directly: q sees d on the
  // same edge as n1, so there is no second stage.
  always @(posedge i_clk) begin
    if (i_reset) begin
      r_n1 <= 1'b0;
      r_q  <= 1'b0;
    end else begin
      r_n1 <= i_d;
      r_q  <= i_d;
    end
  end

  assign o_q = r_q;

  a_collapse: assert property (
    @(posedge i_clk) 1'b1 |=> (r_n1 == r_q)
  );

endmodule

// VHDL-style lane.
// Ports: i_clk, i_reset (sync, high), i_d -> o_q.
module sync_bad_lane_vhd (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_n1;
  logic r_q;

  // Mirrors a process variable: it is updated immediately
  // inside the edge, so anything reading it afterwards in
  // the same edge sees the fresh value.
  function automatic logic proc_var(
    input logic rst,
    input logic din
  );
    logic v;
    v = din;
    if (rst) v = 1'b0;
    return v;
  endfunction

  always_ff @(posedge i_clk) begin
    r_n1 <= proc_var(i_reset, i_d);
    r_q  <= proc_var(i_reset, i_d);
  end

  assign o_q = r_q;

  a_collapse: assert property (
    @(posedge i_clk) 1'b1 |=> (r_n1 == r_q)
  );

endmodule

module sync_bad_top (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q_sv,
  output logic q_v,
  output logic q_vhd
);

  logic w_q_sv;
  logic w_q_v;
  logic w_q_vhd;

  sync_bad_lane_sv u_lane_sv (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (d),
    .o_q     (w_q_sv)
  );

  sync_bad_lane_v u_lane_v (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (d),
    .o_q     (w_q_v)
  );

  sync_bad_lane_vhd u_lane_vhd (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (d),
    .o_q     (w_q_vhd)
  );

  assign q_sv  = w_q_sv;
  assign q_v   = w_q_v;
  assign q_vhd = w_q_vhd;

endmodule

// File: tb/tb_sync_bad_top.sv
// tb_sync_bad_top: scoreboard bench for sync_bad_top.
// Expected q per edge is queued by stimulus, checked by a monitor.
module tb_sync_bad_top;

  logic clk;
  logic reset;
  logic d;
  logic q_sv;
  logic q_v;
  logic q_vhd;

  typedef struct packed {
    logic        exp;
    logic [15:0] edge_n;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  int   edge_cnt;

  sync_bad_top dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q_sv  (q_sv),
    .q_v   (q_v),
    .q_vhd (q_vhd)
  );

  task automatic cmp(input string nm, input logic act,
                     input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic check_now(input string nm, input logic exp);
    cmp({nm, "_q_sv"}, q_sv, exp);
    cmp({nm, "_q_v"}, q_v, exp);
    cmp({nm, "_q_vhd"}, q_vhd, exp);
  endtask

  task automatic push_exp(input logic r, input logic dv);
    exp_t e;
    e.exp    = r ? 1'b0 : dv;
    e.edge_n = 16'(edge_cnt);
    sb.push_back(e);
    edge_cnt++;
  endtask

  // One full 20-unit period; inputs settle 5 units before the edge.
  task automatic edge_in(input logic r, input logic dv);
    reset = r;
    d     = dv;
    push_exp(r, dv);
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    #10;
  endtask

  // Monitor: every rising edge must have an expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_edge: got edge, expected none");
      end else begin
        e = sb.pop_front();
        cmp($sformatf("e%0d_q_sv", e.edge_n), q_sv, e.exp);
        cmp($sformatf("e%0d_q_v", e.edge_n), q_v, e.exp);
        cmp($sformatf("e%0d_q_vhd", e.edge_n), q_vhd, e.exp);
      end
    end
  end

  initial begin
    logic [6:0] alt;
    logic [3:0] glo;
    logic [3:0] ghi;
    clk      = 1'b0;
    reset    = 1'b0;
    d        = 1'b0;
    n_cmp    = 0;
    n_bad    = 0;
    edge_cnt = 0;
    #10;

    // Reset wins over d=1, then release captures d.
    edge_in(1'b1, 1'b1);
    edge_in(1'b0, 1'b1);

    // Single-stage latency: 1 appears right after its edge.
    edge_in(1'b0, 1'b0);
    edge_in(1'b0, 1'b1);

    // clk held low: d toggles 0,1,0,1, outputs hold 0.
    edge_in(1'b0, 1'b0);
    glo = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      d = glo[i];
      #2;
      check_now($sformatf("glow%0d", i), 1'b0);
    end
    edge_in(1'b0, d);

    // clk held high: d toggles 1,0,1,0, outputs hold 0.
    reset = 1'b0;
    d     = 1'b0;
    push_exp(1'b0, 1'b0);
    #5 clk = 1'b1;
    #2;
    ghi = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      d = ghi[i];
      #1;
      check_now($sformatf("ghigh%0d", i), 1'b0);
    end
    clk = 1'b0;
    #10;
    edge_in(1'b0, d);

    // Alternating sequence 0,1,0,1,1,0,0 (first in bit 0).
    alt = 7'b0011010;
    for (int i = 0; i < 7; i++) edge_in(1'b0, alt[i]);

    // Reset pulsed between edges is ignored.
    edge_in(1'b0, 1'b1);
    reset = 1'b1;
    #3;
    reset = 1'b0;
    #2;
    check_now("rst_between", 1'b1);
    edge_in(1'b0, 1'b1);

    // Mid-stream one-edge reset with d=1.
    edge_in(1'b1, 1'b1);
    edge_in(1'b0, 1'b1);

    // Random d and occasional reset.
    for (int i = 0; i < 200; i++) begin
      edge_in(($urandom_range(7) == 0), 1'($urandom_range(1)));
    end

    #5;
    cmp("sb_drain", (sb.size() == 0), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
